sdram_port_arb: RTL and testbench



---
 rtl/sdram_port_arb.sv | 179 +++++++++++++++++
 tb/tb_sdram_port_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arb.sv
// CPU/DMA byte-access slot arbiter in front of the clkref-locked SDRAM controller.
// Build option: SDRAM_ARB_RR_EN selects round-robin instead of fixed DMA-over-CPU priority.
module sdram_port_arb #(
  parameter int unsigned CYCLE_LEN  = 14,
  parameter int unsigned SYNC_PHASE = 1,
  parameter int unsigned READ_PHASE = 7,
  localparam int unsigned ADDR_W    = 25,
  localparam int unsigned DATA_W    = 8,
  localparam int unsigned WORD_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clkref,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_din,
  output logic [DATA_W-1:0] dma_dout,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_aux,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [WORD_W-1:0] mem_dout
);

  localparam int unsigned PH_W = $clog2(CYCLE_LEN);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } port_req_t;

  logic [PH_W-1:0]   ph, ph_nxt;
  logic              clkref_d;
  logic              locked, locked_nxt;
  owner_t            owner, owner_nxt;
  logic              pend, pend_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_aux_nxt, mem_we_nxt;
  logic [DATA_W-1:0] mem_din_nxt, cpu_dout_nxt, dma_dout_nxt;
  logic              cpu_ack_nxt, dma_ack_nxt;

  logic              rise_c, grant_c, read_ph_c, cpu_elig_c, dma_elig_c;
  owner_t            win_c;
  port_req_t         sel_c;
  logic [DATA_W-1:0] lane_c;

`ifdef SDRAM_ARB_RR_EN
  logic              rr_last_dma, rr_last_dma_nxt;
`endif

  assign rise_c     = clkref & ~clkref_d;
  assign grant_c    = locked && (ph == PH_W'(CYCLE_LEN - 1));
  assign read_ph_c  = pend && (ph == PH_W'(READ_PHASE));
  // A port whose access has not yet been acked cannot win again
  assign cpu_elig_c = cpu_req && !(pend && owner == OWN_CPU);
  assign dma_elig_c = dma_req && !(pend && owner == OWN_DMA);
  assign sel_c      = (win_c == OWN_DMA) ? port_req_t'({dma_we, dma_addr, dma_din})
                                         : port_req_t'({cpu_we, cpu_addr, cpu_din});
  assign lane_c     = mem_aux ? mem_dout[WORD_W-1:DATA_W] : mem_dout[DATA_W-1:0];

  // Slot winner selection
  always_comb begin
    win_c = OWN_NONE;
`ifdef SDRAM_ARB_RR_EN
    if (cpu_elig_c && dma_elig_c) win_c = rr_last_dma ? OWN_CPU : OWN_DMA;
    else if (dma_elig_c)          win_c = OWN_DMA;
    else if (cpu_elig_c)          win_c = OWN_CPU;
`else
    if (dma_elig_c)      win_c = OWN_DMA;
    else if (cpu_elig_c) win_c = OWN_CPU;
`endif
  end

  // Phase tracking, grant latch and read-phase ack
  always_comb begin
    ph_nxt       = ph;
    locked_nxt   = locked;
    owner_nxt    = owner;
    pend_nxt     = pend;
    mem_addr_nxt = mem_addr;
    mem_aux_nxt  = mem_aux;
    mem_we_nxt   = mem_we;
    mem_din_nxt  = mem_din;
    cpu_dout_nxt = cpu_dout;
    dma_dout_nxt = dma_dout;
    cpu_ack_nxt  = 1'b0;
    dma_ack_nxt  = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    rr_last_dma_nxt = rr_last_dma;
`endif

    if (rise_c) begin
      ph_nxt     = PH_W'(SYNC_PHASE);
      locked_nxt = 1'b1;
    end else if (ph == PH_W'(CYCLE_LEN - 1)) begin
      ph_nxt = '0;
    end else begin
      ph_nxt = ph + PH_W'(1);
    end

    if (read_ph_c) begin
      pend_nxt = 1'b0;
      if (owner == OWN_CPU) begin
        cpu_ack_nxt = 1'b1;
        if (!mem_we) cpu_dout_nxt = lane_c;
      end
      if (owner == OWN_DMA) begin
        dma_ack_nxt = 1'b1;
        if (!mem_we) dma_dout_nxt = lane_c;
      end
    end

    // Empty slot becomes a harmless dummy read at the previous address
    if (grant_c) begin
      owner_nxt  = win_c;
      pend_nxt   = (win_c != OWN_NONE);
      mem_we_nxt = 1'b0;
      if (win_c != OWN_NONE) begin
        mem_addr_nxt = {1'b0, sel_c.addr[ADDR_W-1:1]};
        mem_aux_nxt  = sel_c.addr[0];
        mem_we_nxt   = sel_c.we;
        mem_din_nxt  = sel_c.din;
`ifdef SDRAM_ARB_RR_EN
        rr_last_dma_nxt = (win_c == OWN_DMA);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clkref_d <= 1'b0;
      ph       <= '0;
      locked   <= 1'b0;
      owner    <= OWN_NONE;
      pend     <= 1'b0;
      mem_addr <= '0;
      mem_aux  <= 1'b0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
      cpu_dout <= '0;
      dma_dout <= '0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      rr_last_dma <= 1'b0;
`endif
    end else begin
      clkref_d <= clkref;
      ph       <= ph_nxt;
      locked   <= locked_nxt;
      owner    <= owner_nxt;
      pend     <= pend_nxt;
      mem_addr <= mem_addr_nxt;
      mem_aux  <= mem_aux_nxt;
      mem_we   <= mem_we_nxt;
      mem_din  <= mem_din_nxt;
      cpu_dout <= cpu_dout_nxt;
      dma_dout <= dma_dout_nxt;
      cpu_ack  <= cpu_ack_nxt;
      dma_ack  <= dma_ack_nxt;
`ifdef SDRAM_ARB_RR_EN
      rr_last_dma <= rr_last_dma_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: vector table of single-port slots plus multi-slot sequences.
module tb_sdram_port_arb;

  localparam int CL = 14;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clkref = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [24:0] dma_addr = '0;
  logic [7:0]  dma_din = '0;
  logic [7:0]  dma_dout;
  logic        dma_ack;
  logic [24:0] mem_addr;
  logic        mem_aux, mem_we;
  logic [7:0]  mem_din;
  logic [15:0] mem_dout = '0;

  sdram_port_arb dut (
    .clk(clk), .reset_n(reset_n), .clkref(clkref),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_dout(dma_dout), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_aux(mem_aux), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dma;
    bit          we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [15:0] mdout;
    logic [24:0] e_addr;
    logic        e_aux;
    logic        e_we;
    logic [7:0]  e_din;
    logic [7:0]  e_dout;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   ref_on = 1'b0, tb_locked = 1'b0, grant_next = 1'b0, mdl_on = 1'b0;
  int   rcnt = 0;
  logic [15:0] sdram_w [8];
  logic [7:0]  ref_mem [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: outputs are sampled and inputs driven on the falling edge
  task automatic tick();
    int r;
    @(negedge clk);
    grant_next = 1'b0;
    if (ref_on) begin
      r = rcnt % CL;
      clkref = (r < 7);
      if (r == 0 && reset_n) tb_locked = 1'b1;
      grant_next = tb_locked && (r == CL - 1);
      rcnt++;
    end else begin
      clkref = 1'b0;
    end
    if (mdl_on) mem_dout = sdram_w[mem_addr[2:0]];
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!grant_next && n < 60) begin
      tick();
      n++;
    end
    if (!grant_next) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: no grant edge within %0d clks", n);
    end
  endtask

  task automatic run_slot(input vec_t v);
    int ack_t, n_ack, n_oth;
    bit stable;
    logic [7:0] dout_at;
    wait_grant();
    if (v.dma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_din = v.din;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din;
    end
    if (!mdl_on) mem_dout = v.mdout;
    ack_t = 0; n_ack = 0; n_oth = 0; stable = 1'b1; dout_at = 'x;
    for (int t = 1; t <= CL; t++) begin
      tick();
      if (t == 1) begin
        chk("mem_addr", 32'(mem_addr), 32'(v.e_addr));
        chk("mem_aux", 32'(mem_aux), 32'(v.e_aux));
        chk("mem_we", 32'(mem_we), 32'(v.e_we));
        chk("mem_din", 32'(mem_din), 32'(v.e_din));
        if (mdl_on && mem_we === 1'b1) begin
          if (mem_aux) sdram_w[mem_addr[2:0]][15:8] = mem_din;
          else         sdram_w[mem_addr[2:0]][7:0]  = mem_din;
        end
      end
      if ({mem_addr, mem_aux, mem_we, mem_din} !== {v.e_addr, v.e_aux, v.e_we, v.e_din})
        stable = 1'b0;
      if (v.dma ? dma_ack : cpu_ack) begin
        n_ack++;
        if (ack_t == 0) ack_t = t;
        dout_at = v.dma ? dma_dout : cpu_dout;
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
      if (v.dma ? cpu_ack : dma_ack) n_oth++;
    end
    chk("ack_latency", 32'(ack_t - 1), 32'd8);
    chk("ack_count", 32'(n_ack), 32'd1);
    chk("other_ack", 32'(n_oth), 32'd0);
    chk("dout", 32'(dout_at), 32'(v.e_dout));
    chk("slot_stable", 32'(stable), 32'd1);
    tick();
    chk("idle_we", 32'(mem_we), 32'd0);
    chk("idle_addr", 32'(mem_addr), 32'(v.e_addr));
  endtask

  vec_t vecs [6];
  bit   exp_seq [4];
  bit   seq [4];

  initial begin
    int ack_t, d_t, c_t, g_t, n, viol;
    logic [7:0] exp_cpu, exp_dma;

    vecs[0] = '{1, 1, 25'h0000200, 8'h5A, 16'h0000, 25'h0000100, 1'b0, 1'b1, 8'h5A, 8'h00};
    vecs[1] = '{1, 0, 25'h1FFFFFF, 8'h00, 16'h1234, 25'h0FFFFFF, 1'b1, 1'b0, 8'h00, 8'h12};
    vecs[2] = '{0, 1, 25'h0000000, 8'hA5, 16'hFFFF, 25'h0000000, 1'b0, 1'b1, 8'hA5, 8'hBE};
    vecs[3] = '{0, 0, 25'h0000FFE, 8'h11, 16'hC3D4, 25'h00007FF, 1'b0, 1'b0, 8'h11, 8'hD4};
    vecs[4] = '{1, 1, 25'h1000001, 8'h3C, 16'h0000, 25'h0800000, 1'b1, 1'b1, 8'h3C, 8'h12};
    vecs[5] = '{0, 0, 25'h0000100, 8'h00, 16'hBEEF, 25'h0000080, 1'b0, 1'b0, 8'h00, 8'hEF};
`ifdef SDRAM_ARB_RR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset values
    repeat (3) tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_aux_din", 32'({mem_aux, mem_din}), 32'd0);
    chk("rst_douts", 32'({cpu_dout, dma_dout}), 32'd0);
    chk("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);

    // Unlocked: request pending but no clkref edge yet
    reset_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000101; mem_dout = 16'hBEEF;
    viol = 0;
    repeat (100) begin
      tick();
      if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || mem_we !== 1'b0) viol++;
    end
    chk("unlocked_quiet", 32'(viol), 32'd0);

    // First lock: grant at the first ph==CYCLE_LEN-1, ack 8 clks later
    ref_on = 1'b1; rcnt = 0; ack_t = -1;
    for (int t = 1; t <= 60 && ack_t < 0; t++) begin
      tick();
      if (cpu_ack) ack_t = t;
    end
    chk("lock_ack_tick", 32'(ack_t), 32'd23);
    chk("lock_cpu_dout", 32'(cpu_dout), 32'hBE);
    chk("lock_mem_addr", 32'(mem_addr), 32'h80);
    chk("lock_mem_aux", 32'(mem_aux), 32'd1);
    chk("lock_mem_we", 32'(mem_we), 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("lock_ack_pulse", 32'(cpu_ack), 32'd0);

    for (int i = 0; i < 6; i++) run_slot(vecs[i]);

    // Slots against a byte-array reference; the bench plays the SDRAM
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 17 + 3);
    for (int j = 0; j < 8; j++) sdram_w[j] = {ref_mem[2*j+1], ref_mem[2*j]};
    exp_cpu = 8'hEF; exp_dma = 8'h12;
    mdl_on = 1'b1;
    for (int s = 0; s < 40; s++) begin
      vec_t v;
      int a;
      a = int'($urandom_range(0, 15));
      v.dma = 1'($urandom_range(0, 1));
      v.we = 1'($urandom_range(0, 1));
      v.addr = 25'(a);
      v.din = 8'($urandom);
      v.mdout = '0;
      v.e_addr = 25'(a / 2);
      v.e_aux = 1'(a % 2);
      v.e_we = v.we;
      v.e_din = v.din;
      if (v.we) begin
        ref_mem[a] = v.din;
        v.e_dout = v.dma ? exp_dma : exp_cpu;
      end else begin
        v.e_dout = ref_mem[a];
        if (v.dma) exp_dma = ref_mem[a];
        else       exp_cpu = ref_mem[a];
      end
      run_slot(v);
    end
    mdl_on = 1'b0;
    run_slot(vecs[5]);

    // Both ports at the same grant
    wait_grant();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 25'h10; dma_din = 8'h77;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h21; mem_dout = 16'h5566;
    d_t = -1; c_t = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (dma_ack) begin if (d_t < 0) d_t = t; dma_req = 1'b0; end
      if (cpu_ack) begin if (c_t < 0) c_t = t; cpu_req = 1'b0; end
    end
    chk("both_dma_tick", 32'(d_t), 32'd9);
    chk("both_cpu_tick", 32'(c_t), 32'd23);
    chk("both_cpu_dout", 32'(cpu_dout), 32'h55);

    // Both held across four slots
    wait_grant();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 25'h20;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h21;
    n = 0;
    for (int t = 1; t <= 56; t++) begin
      tick();
      if (dma_ack || cpu_ack) begin
        if (n < 4) seq[n] = dma_ack;
        n++;
        if (n == 4) begin dma_req = 1'b0; cpu_req = 1'b0; end
      end
    end
    chk("held_ack_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("held_slot%0d_dma", i), 32'(seq[i]), 32'(exp_seq[i]));

    // Reset in the middle of a DMA write slot
    wait_grant();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 25'h300; dma_din = 8'h66;
    repeat (4) tick();
    chk("mid_we_before", 32'(mem_we), 32'd1);
    reset_n = 1'b0; tb_locked = 1'b0;
    tick();
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_ack", 32'(dma_ack), 32'd0);
    n = 0;
    while (clkref && n < 20) begin tick(); n++; end
    reset_n = 1'b1;
    g_t = -1; ack_t = -1;
    for (int t = 1; t <= 60 && ack_t < 0; t++) begin
      tick();
      if (grant_next && g_t < 0) g_t = t;
      if (dma_ack) ack_t = t;
    end
    chk("mid_relock_lat", 32'(ack_t - g_t), 32'd9);
    chk("mid_regrant_we", 32'(mem_we), 32'd1);
    chk("mid_regrant_addr", 32'(mem_addr), 32'h180);
    dma_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
